// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, default bit period, parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // 50 MHz system clock, 115200 baud.
  localparam int unsigned UART_BR_DEFAULT = 434;

  // Parity bit that makes the frame correct: even -> XOR of data, odd -> its inverse.
  // Unused upper bits must be zero.
  function automatic logic uart_parity(input logic [63:0] bits, input logic odd);
    return (^bits) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the input through two flops; reset to the line's idle level.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= {2{RST_VAL}};
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_byte.sv
// UART receiver: mid-bit sampling, start-glitch rejection, parity and framing checks.
// DATA_WIDTH must be at least 2.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned BR         = UART_BR_DEFAULT,
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  rx_en,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_vld,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(BR);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(BR / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(BR - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  logic rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  uart_state_e           state_q, state_d;
  logic [CNT_W-1:0]      br_cnt_q, br_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bad_q, par_bad_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  data_vld_q, data_vld_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      br_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      data_q       <= '0;
      data_vld_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      br_cnt_q     <= br_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      data_q       <= data_d;
      data_vld_q   <= data_vld_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state logic: one sample per bit, taken when the bit-period counter expires.
  always_comb begin
    state_d      = state_q;
    br_cnt_d     = br_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    data_d       = data_q;
    data_vld_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    unique case (state_q)
      IDLE: begin
        if (rx_en && !rx_s) begin
          state_d  = START;
          br_cnt_d = '0;
        end
      end
      START: begin
        if (br_cnt_q == HALF_M1) begin
          br_cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_bad_d = 1'b0;
          end
        end else begin
          br_cnt_d = br_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (br_cnt_q == FULL_M1) begin
          br_cnt_d  = '0;
          shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = PARITY_EN ? PARITY : STOP;
        end else begin
          br_cnt_d = br_cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (br_cnt_q == FULL_M1) begin
          br_cnt_d  = '0;
          par_bad_d = (rx_s != uart_parity(64'(shift_q), PARITY_ODD));
          state_d   = STOP;
        end else begin
          br_cnt_d = br_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (br_cnt_q == FULL_M1) begin
          br_cnt_d     = '0;
          state_d      = IDLE;
          data_vld_d   = 1'b1;
          data_d       = shift_q;
          parity_err_d = PARITY_EN ? par_bad_q : 1'b0;
          frame_err_d  = ~rx_s;
        end else begin
          br_cnt_d = br_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data       = data_q;
  assign data_vld   = data_vld_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: an even-parity and an odd-parity receiver share one line.
module tb_uart_rx_byte;

  localparam int unsigned BR = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_en = 1'b0;
  logic [7:0] data_e, data_o;
  logic       vld_e, vld_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

  uart_rx_byte #(.BR(BR), .DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_e (
    .clk(clk), .rst(rst), .rx(rx), .rx_en(rx_en), .data(data_e), .data_vld(vld_e),
    .parity_err(perr_e), .frame_err(ferr_e), .busy(busy_e)
  );

  uart_rx_byte #(.BR(BR), .DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_o (
    .clk(clk), .rst(rst), .rx(rx), .rx_en(rx_en), .data(data_o), .data_vld(vld_o),
    .parity_err(perr_o), .frame_err(ferr_o), .busy(busy_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t        q_e[$];
  exp_t        q_o[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned last_vld = 0;
  int unsigned prev_vld = 0;
  int unsigned start_cyc = 0;
  logic        busy_seen = 1'b0;
  logic        pb_e = 1'b0;
  logic        pb_o = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect2(input logic [7:0] d, input logic pe_e, input logic pe_o, input logic fe);
    exp_t x;
    x.d = d; x.fe = fe;
    x.pe = pe_e; q_e.push_back(x);
    x.pe = pe_o; q_o.push_back(x);
  endtask

  task automatic hold(input logic b, input int unsigned n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    start_cyc = cyc;
    hold(1'b0, BR);
    for (int i = 0; i < 8; i++) hold(d[i], BR);
    hold(p, BR);
    hold(s, BR);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q_e.size() != 0 || q_o.size() != 0) && n < 40 * BR) begin
      @(negedge clk);
      n++;
    end
    check(name, q_e.size() + q_o.size(), 0);
  endtask

  initial begin
    exp_t xe, xo;
    fork
      forever begin
        @(negedge clk);
        if (busy_e || busy_o) busy_seen = 1'b1;
        if (vld_e) begin
          if (q_e.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_vld_e: data_vld=1 data=0x%0h required no pulse", data_e);
          end else begin
            xe = q_e.pop_front();
            check("data_e", data_e, xe.d);
            check("perr_e", perr_e, xe.pe);
            check("ferr_e", ferr_e, xe.fe);
            check("busy_edge_e", {pb_e, busy_e}, 2'b10);
          end
          prev_vld = last_vld;
          last_vld = cyc;
        end
        if (vld_o) begin
          if (q_o.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_vld_o: data_vld=1 data=0x%0h required no pulse", data_o);
          end else begin
            xo = q_o.pop_front();
            check("data_o", data_o, xo.d);
            check("perr_o", perr_o, xo.pe);
            check("ferr_o", ferr_o, xo.fe);
            check("busy_edge_o", {pb_o, busy_o}, 2'b10);
          end
        end
        pb_e = busy_e;
        pb_o = busy_o;
      end
    join_none

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_e", {data_e, vld_e, perr_e, ferr_e, busy_e}, 0);
    check("reset_o", {data_o, vld_o, perr_o, ferr_o, busy_o}, 0);
    rx_en = 1'b1;
    hold(1'b1, 2 * BR);

    // 0xA5, parity 0 (even-correct), stop 1; latency from pin = 8 + 160 + 1 + 2
    expect2(8'hA5, 1'b0, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1);
    hold(1'b1, 2 * BR);
    wait_drain("drain_a5");
    check("latency_a5", last_vld - start_cyc, 171);

    // 0x3C with parity 1: wrong for even, right for odd
    expect2(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1);
    hold(1'b1, 2 * BR);
    wait_drain("drain_3c");

    // 0x81 with stop 0, line held low: a new all-zero frame starts; line rises during its stop bit
    expect2(8'h81, 1'b0, 1'b1, 1'b1);
    expect2(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0);
    hold(1'b0, BR);
    check("restart_busy", {busy_e, busy_o}, 2'b11);
    hold(1'b0, 138);
    hold(1'b1, 3 * BR);
    wait_drain("drain_81");

    // 5-clk start glitch is rejected, then a valid 0x5A
    busy_seen = 1'b0;
    hold(1'b0, 5);
    hold(1'b1, 2 * BR);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_idle", {busy_e, busy_o}, 2'b00);
    expect2(8'h5A, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    hold(1'b1, 2 * BR);
    wait_drain("drain_5a");

    // Back-to-back 0x00 then 0xFF, no idle gap
    expect2(8'h00, 1'b0, 1'b1, 1'b0);
    expect2(8'hFF, 1'b0, 1'b1, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    hold(1'b1, 2 * BR);
    wait_drain("drain_b2b");
    check("b2b_spacing", last_vld - prev_vld, 11 * BR);

    // Reset during the data bits of 0x77 aborts it
    hold(1'b0, BR);
    hold(1'b1, 3 * BR);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    check("midreset_e", {data_e, vld_e, perr_e, ferr_e, busy_e}, 0);
    check("midreset_o", {data_o, vld_o, perr_o, ferr_o, busy_o}, 0);
    hold(1'b1, 2 * BR);
    expect2(8'h77, 1'b0, 1'b1, 1'b0);
    send_frame(8'h77, 1'b0, 1'b1);
    hold(1'b1, 2 * BR);
    wait_drain("drain_77");

    // rx_en low while a frame arrives: nothing starts
    rx_en = 1'b0;
    busy_seen = 1'b0;
    send_frame(8'h00, 1'b0, 1'b1);
    hold(1'b1, 2 * BR);
    check("rx_en_off_busy", busy_seen, 0);
    rx_en = 1'b1;
    expect2(8'hC3, 1'b0, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1);
    hold(1'b1, 2 * BR);
    wait_drain("drain_c3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial receive stage that consumes the rx pin and delivers one parallel byte per frame to the UART command FSM, which uses it as read_data and read_rdy.
- Frame format: 1 start bit (0), DATA_WIDTH data bits sent LSB first, an optional parity bit, 1 stop bit (1).
- Each bit is sampled once, at its mid-point, using a bit-period counter of BR clocks.
- Start-bit glitches are rejected; parity and framing errors are flagged alongside the data.

Parameters:
BR, 434, clocks per bit period (50 MHz / 115200 baud); must be >= 4.
DATA_WIDTH, 8, data bits per frame.
PARITY_EN, 1, 1 = a parity bit is present and checked; 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  synchronous, active-high reset.
rx  input  1  asynchronous serial line; idles high.
rx_en  input  1  receive enable; a new frame starts only while this is 1.
data  output  DATA_WIDTH  last received byte; held until the next data_vld.
data_vld  output  1  one-clk pulse when a frame completes.
parity_err  output  1  valid with data_vld; 1 = parity mismatch.
frame_err  output  1  valid with data_vld; 1 = stop bit sampled as 0.
busy  output  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset: all state is cleared on the clk edge with rst = 1, including mid-frame. After reset: FSM in IDLE, counters 0, data = 0, data_vld = 0, parity_err = 0, frame_err = 0, busy = 0; synchronizer flops preset to 1.
- Synchronizer: rx passes through a 2-flop synchronizer to give rx_s, adding 2 clk of latency. No other logic reads rx directly.
- Counters: br_cnt counts 0..BR-1; bit_cnt has width $clog2(DATA_WIDTH+1).
- IDLE:
  - Moves to START when rx_en = 1 and rx_s = 0; br_cnt is cleared.
  - rx_en is sampled only in IDLE; dropping it mid-frame does not abort the frame.
- START:
  - br_cnt increments each clk.
  - At br_cnt == BR/2-1 (integer division), rx_s is sampled.
  - Sample = 1: glitch; return to IDLE with no outputs.
  - Sample = 0: move to DATA with br_cnt = 0 and bit_cnt = 0.
- DATA:
  - Sample at br_cnt == BR-1, which is mid-bit; then clear br_cnt.
  - The sample shifts in MSB-side, so bit 0 is received first and data lands LSB first.
  - After DATA_WIDTH samples, go to PARITY if PARITY_EN = 1, else to STOP.
- PARITY:
  - Sample at br_cnt == BR-1.
  - par_bad = (XOR of data bits XOR sampled bit) != PARITY_ODD.
- STOP:
  - Sample at br_cnt == BR-1.
  - In the next clk: data_vld = 1, the data register updates, parity_err = par_bad (0 when PARITY_EN = 0), frame_err = ~stop_sample.
  - The FSM goes straight to IDLE; there is no wait for the line to return high.
  - A frame_err frame whose line stays low is therefore seen as a new start in IDLE.
- Data on error: data is delivered on data_vld even when an error flag is set. The consumer discards the byte.
- Output hold: data, parity_err and frame_err hold their values until the next data_vld. data_vld is high for exactly 1 clk.
- Latency: data_vld rises BR/2 + BR*(DATA_WIDTH+PARITY_EN+1) + 1 clk after the first cycle rx_s = 0. For the defaults this is 217 + 4340 + 1 = 4558 clk, plus 2 clk of synchronizer delay from the pin.
- Back-to-back frames: a start bit that immediately follows a stop bit is caught. Sampling at mid-stop leaves BR/2 clk of margin.
- Overrun: there is no backpressure. The consumer must take data within one frame time.
- busy is 1 in START, DATA, PARITY and STOP.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the default BR constant (434);
  - a parity-function helper, also used by the transmit side.
- Sub-module uart_sync2 is the 2-flop synchronizer with a reset value parameter (1 for rx). It is reused by the transmit/command FSM for its rx input.

Test Plan:
- BR = 16, even parity; send 0xA5 with parity 0 and stop 1 -> one data_vld pulse, data = 0xA5, parity_err = 0, frame_err = 0, busy back to 0 the next clk.
- Send 0x3C with parity bit 1 (wrong for even) -> data = 0x3C, parity_err = 1, frame_err = 0; repeat with PARITY_ODD = 1 -> parity_err = 0.
- Send 0x81 with stop bit 0 -> data = 0x81, frame_err = 1; rx held low afterwards -> a new frame starts (busy = 1).
- Low pulse of 5 clk (< BR/2 = 8) on an idle line -> busy high briefly, then IDLE, no data_vld; following valid frame 0x5A -> received correctly.
- Two back-to-back frames 0x00 then 0xFF with no idle gap -> two data_vld pulses spaced exactly 11*BR = 176 clk apart, correct data, no errors.
- Assert rst for 1 clk midway through the data bits of a frame -> outputs = reset values; no data_vld for that frame; next full frame 0x77 -> received correctly. Also check rx_en = 0 when the start bit arrives -> no reception.
